wb_port_arbiter: RTL and testbench

- Shares the single register-file write port, and the 3:1 writeback select mux in front of it, between three result producers.
- Producers: ALU (a, sel 2'b00), load unit (b, sel 2'b01), PC+4/link path (c, sel 2'b10).
- Grants one producer per cycle under fixed priority with aging-based starvation override.
- Drives the mux select, the register-file write enable and the destination register index.

---
 rtl/wb_port_arbiter.sv | 122 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Writeback-port arbiter: three producers share the register-file write port.
// Fixed priority a > b > c, with aging override. Optional counters: WB_ARB_STATS_EN.
module wb_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 4
`ifdef WB_ARB_STATS_EN
  , parameter int unsigned STAT_W     = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       req_valid,
  input  logic [4:0]       rd_a,
  input  logic [4:0]       rd_b,
  input  logic [4:0]       rd_c,
  output logic [2:0]       req_ready,
  output logic [1:0]       sel,
  output logic             reg_write,
  output logic [4:0]       rd_out
`ifdef WB_ARB_STATS_EN
  , output logic [STAT_W-1:0] stat_grant_a,
  output logic [STAT_W-1:0] stat_grant_b,
  output logic [STAT_W-1:0] stat_grant_c,
  output logic [STAT_W-1:0] stat_conflict,
  output logic [STAT_W-1:0] stat_starve
`endif
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] age_q [3];
  logic [CNT_W-1:0] age_d [3];
  logic [1:0]       last_sel_q, last_sel_d;
  logic [2:0]       starved;
  logic [2:0]       grant;
  logic [1:0]       win_idx;
  logic             starve_win;
  logic [4:0]       rd_win;

  // Starvation only counts for a requester still asserting valid this cycle.
  always_comb begin
    starved    = '0;
    grant      = '0;
    win_idx    = 2'b00;
    starve_win = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      starved[i] = req_valid[i] && (age_q[i] == LIMIT);
    end
    if (!rst) begin
      if (|starved) begin
        starve_win = 1'b1;
        if (starved[0])      begin grant = 3'b001; win_idx = 2'b00; end
        else if (starved[1]) begin grant = 3'b010; win_idx = 2'b01; end
        else                 begin grant = 3'b100; win_idx = 2'b10; end
      end else if (req_valid[0]) begin grant = 3'b001; win_idx = 2'b00; end
      else if (req_valid[1])     begin grant = 3'b010; win_idx = 2'b01; end
      else if (req_valid[2])     begin grant = 3'b100; win_idx = 2'b10; end
    end
  end

  always_comb begin
    rd_win = 5'd0;
    case (grant)
      3'b001:  rd_win = rd_a;
      3'b010:  rd_win = rd_b;
      3'b100:  rd_win = rd_c;
      default: rd_win = 5'd0;
    endcase
  end

  always_comb begin
    req_ready  = grant;
    rd_out     = rd_win;
    reg_write  = (|grant) && (rd_win != 5'd0);
    last_sel_d = (|grant) ? win_idx : last_sel_q;
    sel        = rst ? 2'b00 : last_sel_d;
  end

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      if (!req_valid[i] || grant[i])
        age_d[i] = '0;
      else if (age_q[i] == LIMIT)
        age_d[i] = age_q[i];
      else
        age_d[i] = age_q[i] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 3; i++) age_q[i] <= '0;
      last_sel_q <= 2'b00;
    end else begin
      for (int unsigned i = 0; i < 3; i++) age_q[i] <= age_d[i];
      last_sel_q <= last_sel_d;
    end
  end

`ifdef WB_ARB_STATS_EN
  logic conflict;
  assign conflict = (req_valid[0] & req_valid[1]) | (req_valid[0] & req_valid[2]) |
                    (req_valid[1] & req_valid[2]);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grant_a  <= '0;
      stat_grant_b  <= '0;
      stat_grant_c  <= '0;
      stat_conflict <= '0;
      stat_starve   <= '0;
    end else begin
      if (grant[0])   stat_grant_a  <= stat_grant_a + STAT_W'(1);
      if (grant[1])   stat_grant_b  <= stat_grant_b + STAT_W'(1);
      if (grant[2])   stat_grant_c  <= stat_grant_c + STAT_W'(1);
      if (conflict)   stat_conflict <= stat_conflict + STAT_W'(1);
      if (starve_win) stat_starve   <= stat_starve + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a rule-level model predicts each cycle's
// outputs, a negedge monitor pops and compares. Optional counters: WB_ARB_STATS_EN.
module tb_wb_port_arbiter;

  localparam int LIMIT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req_valid = '0;
  logic [4:0] rd_a = '0, rd_b = '0, rd_c = '0;
  logic [2:0] req_ready;
  logic [1:0] sel;
  logic       reg_write;
  logic [4:0] rd_out;
`ifdef WB_ARB_STATS_EN
  logic [31:0] stat_grant_a, stat_grant_b, stat_grant_c, stat_conflict, stat_starve;
`endif

  wb_port_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .rd_a(rd_a), .rd_b(rd_b), .rd_c(rd_c),
    .req_ready(req_ready), .sel(sel), .reg_write(reg_write), .rd_out(rd_out)
`ifdef WB_ARB_STATS_EN
    , .stat_grant_a(stat_grant_a), .stat_grant_b(stat_grant_b), .stat_grant_c(stat_grant_c),
    .stat_conflict(stat_conflict), .stat_starve(stat_starve)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] ready;
    logic [1:0] sel;
    logic       rw;
    logic [4:0] rd;
    int         stats [5];
  } exp_t;

  exp_t sb [$];
  int checks = 0;
  int failures = 0;

  // Reference model state: what the spec says each requester has waited, etc.
  int age [3];
  int last_sel = 0;
  int st [5];              // grant a, grant b, grant c, conflict, starve
  logic       cur_rst = 1'b1;
  logic [2:0] cur_v = '0;
  int         cur_g = -1;
  bit         cur_starve = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("req_ready", int'(req_ready), int'(e.ready));
      chk("sel", int'(sel), int'(e.sel));
      chk("reg_write", int'(reg_write), int'(e.rw));
      chk("rd_out", int'(rd_out), int'(e.rd));
`ifdef WB_ARB_STATS_EN
      chk("stat_grant_a", int'(stat_grant_a), e.stats[0]);
      chk("stat_grant_b", int'(stat_grant_b), e.stats[1]);
      chk("stat_grant_c", int'(stat_grant_c), e.stats[2]);
      chk("stat_conflict", int'(stat_conflict), e.stats[3]);
      chk("stat_starve", int'(stat_starve), e.stats[4]);
`endif
    end
  end

  // Fold the cycle that just ended into the model.
  task automatic commit();
    if (cur_rst) begin
      for (int i = 0; i < 3; i++) age[i] = 0;
      for (int i = 0; i < 5; i++) st[i] = 0;
      last_sel = 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!cur_v[i] || cur_g == i) age[i] = 0;
        else age[i] = (age[i] + 1 > LIMIT) ? LIMIT : age[i] + 1;
      end
      if (cur_g >= 0) begin
        last_sel = cur_g;
        st[cur_g]++;
      end
      if ((int'(cur_v[0]) + int'(cur_v[1]) + int'(cur_v[2])) >= 2) st[3]++;
      if (cur_starve) st[4]++;
    end
  endtask

  task automatic drive(input logic r, input logic [2:0] v,
                       input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rc);
    exp_t e;
    logic [4:0] rds [3];
    int g;
    bit sw;
    @(posedge clk);
    #1;
    commit();
    rst = r; req_valid = v; rd_a = ra; rd_b = rb; rd_c = rc;
    rds[0] = ra; rds[1] = rb; rds[2] = rc;
    g = -1;
    sw = 0;
    if (!r) begin
      for (int i = 0; i < 3; i++)
        if (g < 0 && v[i] && age[i] >= LIMIT) begin g = i; sw = 1; end
      for (int i = 0; i < 3; i++)
        if (g < 0 && v[i]) g = i;
    end
    if (r) begin
      e.ready = '0; e.sel = 2'b00; e.rw = 1'b0; e.rd = '0;
    end else if (g >= 0) begin
      e.ready = 3'(1 << g); e.sel = 2'(g); e.rd = rds[g]; e.rw = (rds[g] != 5'd0);
    end else begin
      e.ready = '0; e.sel = 2'(last_sel); e.rw = 1'b0; e.rd = '0;
    end
    for (int i = 0; i < 5; i++) e.stats[i] = st[i];
    sb.push_back(e);
    cur_rst = r; cur_v = v; cur_g = g; cur_starve = sw;
  endtask

  initial begin
    logic [2:0] v;
    logic [4:0] rd [3];
    logic       r;

    // Reset with everything requesting, then release: a wins.
    drive(1, 3'b111, 5'd1, 5'd2, 5'd3);
    drive(1, 3'b111, 5'd1, 5'd2, 5'd3);
    drive(0, 3'b001, 5'd1, 5'd2, 5'd3);
    // Single b, then idle holds sel=01.
    drive(0, 3'b010, 5'd0, 5'd7, 5'd0);
    drive(0, 3'b000, 5'd0, 5'd7, 5'd0);
    drive(0, 3'b000, 5'd0, 5'd7, 5'd0);
    // Priority, one cycle.
    drive(0, 3'b111, 5'd1, 5'd2, 5'd3);
    drive(0, 3'b000, 5'd1, 5'd2, 5'd3);
    // Starvation: a re-asserts every cycle, c waits.
    drive(1, 3'b000, 5'd0, 5'd0, 5'd0);
    for (int k = 0; k < 5; k++) drive(0, 3'b101, 5'(k + 10), 5'd0, 5'd9);
    drive(0, 3'b001, 5'd20, 5'd0, 5'd9);
    drive(0, 3'b000, 5'd0, 5'd0, 5'd0);
    // Two starved: b then c.
    for (int k = 0; k < 4; k++) drive(0, 3'b111, 5'(k + 1), 5'd4, 5'd5);
    drive(0, 3'b111, 5'd8, 5'd4, 5'd5);
    drive(0, 3'b101, 5'd8, 5'd4, 5'd5);
    drive(0, 3'b001, 5'd8, 5'd4, 5'd5);
    drive(0, 3'b000, 5'd0, 5'd0, 5'd0);
    // x0 write suppressed, grant still completes.
    drive(0, 3'b001, 5'd0, 5'd0, 5'd0);
    // b ages to 3, reset mid-wait, then needs 4 more blocked cycles.
    for (int k = 0; k < 3; k++) drive(0, 3'b011, 5'd1, 5'd6, 5'd0);
    drive(1, 3'b011, 5'd1, 5'd6, 5'd0);
    for (int k = 0; k < 6; k++) drive(0, 3'b011, 5'd1, 5'd6, 5'd0);
    drive(0, 3'b000, 5'd0, 5'd0, 5'd0);

    // Random traffic respecting hold-until-granted, with rare drops and resets.
    v = '0;
    for (int i = 0; i < 3; i++) rd[i] = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!v[i] && $urandom_range(0, 2) != 0) begin
          v[i] = 1'b1;
          rd[i] = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        end else if (v[i] && $urandom_range(0, 99) == 0) begin
          v[i] = 1'b0;
        end
      end
      r = ($urandom_range(0, 149) == 0);
      drive(r, v, rd[0], rd[1], rd[2]);
      if (cur_g >= 0) v[cur_g] = 1'b0;
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
